// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle divider: FSM state codes and
// handshake levels used by div_unit.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not go negative.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] next_rem,
  output logic             qbit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // The remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
  always_comb begin
    shifted_s = {partial_rem, next_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    qbit      = ~diff_s[WIDTH];
    if (qbit) begin
      next_rem = diff_s[WIDTH-1:0];
    end else begin
      next_rem = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU beside the EX stage: one quotient
// bit per cycle, returns {remainder, quotient} with ready_o handshake.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  div_state_e         state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [WIDTH-1:0]   rem_r, rem_s;
  logic [WIDTH-1:0]   dvd_r, dvd_s;
  logic [WIDTH-1:0]   dvs_r, dvs_s;
  logic               neg1_r, neg1_s, neg2_r, neg2_s, sgn_r, sgn_s;
  logic [2*WIDTH-1:0] result_r, result_s;
  logic               ready_r, ready_s;
  logic [WIDTH-1:0]   step_rem_s, quot_s, quot_fix_s, rem_fix_s;
  logic [WIDTH-1:0]   abs1_s, abs2_s;
  logic               qbit_s;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem (rem_r),
    .divisor     (dvs_r),
    .next_bit    (dvd_r[WIDTH-1]),
    .next_rem    (step_rem_s),
    .qbit        (qbit_s)
  );

  // Operand magnitudes and final sign fix-up; the most-negative / -1 case wraps naturally.
  always_comb begin
    quot_s = {dvd_r[WIDTH-2:0], qbit_s};
    if (signed_div_i && opdata1_i[WIDTH-1]) begin
      abs1_s = -opdata1_i;
    end else begin
      abs1_s = opdata1_i;
    end
    if (signed_div_i && opdata2_i[WIDTH-1]) begin
      abs2_s = -opdata2_i;
    end else begin
      abs2_s = opdata2_i;
    end
    if (sgn_r && (neg1_r ^ neg2_r)) begin
      quot_fix_s = -quot_s;
    end else begin
      quot_fix_s = quot_s;
    end
    if (sgn_r && neg1_r) begin
      rem_fix_s = -step_rem_s;
    end else begin
      rem_fix_s = step_rem_s;
    end
  end

  // Next-state, datapath and output logic; dividend register doubles as quotient shifter.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    rem_s    = rem_r;
    dvd_s    = dvd_r;
    dvs_s    = dvs_r;
    neg1_s   = neg1_r;
    neg2_s   = neg2_r;
    sgn_s    = sgn_r;
    result_s = result_r;
    ready_s  = ready_r;
    case (state_r)
      DIV_FREE: begin
        ready_s  = DIV_RESULT_NOT_READY;
        result_s = {(2*WIDTH){1'b0}};
        if ((start_i == DIV_START) && !annul_i) begin
          if (opdata2_i == {WIDTH{1'b0}}) begin
            state_s = DIV_BY_ZERO;
          end else begin
            state_s = DIV_ON;
            cnt_s   = {CNT_W{1'b0}};
            rem_s   = {WIDTH{1'b0}};
            dvd_s   = abs1_s;
            dvs_s   = abs2_s;
            neg1_s  = signed_div_i & opdata1_i[WIDTH-1];
            neg2_s  = signed_div_i & opdata2_i[WIDTH-1];
            sgn_s   = signed_div_i;
          end
        end else begin
          state_s = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        result_s = {(2*WIDTH){1'b0}};
        if (annul_i) begin
          state_s = DIV_FREE;
          ready_s = DIV_RESULT_NOT_READY;
        end else begin
          state_s = DIV_END;
          ready_s = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_s  = DIV_FREE;
          ready_s  = DIV_RESULT_NOT_READY;
          result_s = {(2*WIDTH){1'b0}};
        end else begin
          rem_s = step_rem_s;
          dvd_s = quot_s;
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_W'(WIDTH-1)) begin
            state_s  = DIV_END;
            result_s = {rem_fix_s, quot_fix_s};
            ready_s  = DIV_RESULT_READY;
          end else begin
            state_s = DIV_ON;
          end
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_s  = DIV_FREE;
          ready_s  = DIV_RESULT_NOT_READY;
          result_s = {(2*WIDTH){1'b0}};
        end else begin
          state_s = DIV_END;
        end
      end
      default: begin
        state_s  = DIV_FREE;
        ready_s  = DIV_RESULT_NOT_READY;
        result_s = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= DIV_FREE;
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      dvd_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      neg1_r   <= 1'b0;
      neg2_r   <= 1'b0;
      sgn_r    <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
      ready_r  <= DIV_RESULT_NOT_READY;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rem_r    <= rem_s;
      dvd_r    <= dvd_s;
      dvs_r    <= dvs_s;
      neg1_r   <= neg1_s;
      neg2_r   <= neg2_s;
      sgn_r    <= sgn_s;
      result_r <= result_s;
      ready_r  <= ready_s;
    end
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule
